// File: rtl/dmem_load_store_responder.sv
// Load/store data-memory responder for the memory slot of the RV32I pipe.
// Byte-enable writes, one-cycle registered reads, and misalignment and range error flags.
module dmem_load_store_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_mem_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] hazard_addr_i,
  output logic [31:0]       hazard_data_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              misalign_o,
  output logic              range_err_o,
  output logic              err_sticky_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_load;
  logic             is_store;
  logic             store_width_ok;
  logic             is_half;
  logic             is_word;
  logic             misaligned;
  logic             out_of_range;
  logic             access;
  logic             mis_c;
  logic             rng_c;
  logic             accept;
  logic             we;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      read_word;
  logic [31:0]      lane;
  logic [31:0]      ext_data;

  logic [31:0] rd_word_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        mis_q;
  logic        rng_q;
  logic        sticky_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, instr_mem_i[31:15], instr_mem_i[11:7], hazard_addr_i[ADDR_W-1:2]};

  // Decode, error classification and store lane steering.
  always_comb begin
    opcode         = instr_mem_i[6:0];
    funct3         = instr_mem_i[14:12];
    is_load        = (opcode == OPC_LOAD);
    is_store       = (opcode == OPC_STORE);
    store_width_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    is_half        = (funct3 == 3'b001) || (is_load && (funct3 == 3'b101));
    is_word        = (funct3 == 3'b010);
    misaligned     = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    out_of_range   = (addr_i >= ADDR_LIMIT);
    access         = is_load || (is_store && store_width_ok);
    mis_c          = access && misaligned;
    rng_c          = access && out_of_range && !misaligned;
    accept         = !rst_i && !hold_i;
    we             = accept && is_store && store_width_ok && !misaligned && !out_of_range;
    idx            = addr_i[IDX_W+1:2];
    be             = 4'b0000;
    wdata          = store_data_i;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << addr_i[1:0];
        wdata = {4{store_data_i[7:0]}};
      end
      3'b001: begin
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data_i[15:0]}};
      end
      3'b010: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load path: fetch the word, align the lane, and extend according to width.
  always_comb begin
    read_word = out_of_range ? 32'h0 : mem[idx];
    lane      = read_word >> {addr_i[1:0], 3'b000};
    ext_data  = 32'h0;
    case (funct3)
      3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
      3'b010:  ext_data = read_word;
      3'b100:  ext_data = {24'h0, lane[7:0]};
      3'b101:  ext_data = {16'h0, lane[15:0]};
      default: ext_data = 32'h0;
    endcase
    if (misaligned) ext_data = 32'h0;
  end

  // Array is not reset; a write only happens on an accepted, legal store.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Result and status registers; hold freezes everything except the error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_word_q    <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      rng_q        <= 1'b0;
      sticky_q     <= 1'b0;
    end else if (hold_i) begin
      mis_q <= 1'b0;
      rng_q <= 1'b0;
    end else begin
      if (is_load) begin
        rd_word_q   <= read_word;
        load_data_q <= ext_data;
      end
      load_valid_q <= is_load;
      mis_q        <= mis_c;
      rng_q        <= rng_c;
      sticky_q     <= sticky_q || mis_c || rng_c;
    end
  end

  assign hazard_data_o = rd_word_q >> {hazard_addr_i[1:0], 3'b000};
  assign load_data_o   = load_data_q;
  assign load_valid_o  = load_valid_q;
  assign misalign_o    = mis_q;
  assign range_err_o   = rng_q;
  assign err_sticky_o  = sticky_q;

endmodule
